ras_ctrl: RTL and testbench

RAS_CTRL -- requirements
Module: ras_ctrl

---
 rtl/ras_ctrl.sv | 127 ++++++++++++
 tb/tb_ras_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ras_ctrl.sv
// ras_ctrl: speculative return-address-stack controller with drain/resync on flush.
// Ports: clk, reset_n, req_* (fetch actions), cmt_* (retire), flush,
//        stg_* (stage control), tos_addr, inflight, busy, stat_stalls.
// Macro RAS_CTRL_STATS_EN: enables the saturating stall counter on stat_stalls.
module ras_ctrl #(
  parameter int DEPTH      = 16,
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  input  logic                    req_push,
  input  logic                    req_pop,
  input  logic [WIDTH-1:0]        req_data,
  output logic                    req_ready,
  input  logic                    cmt_valid,
  output logic                    cmt_ready,
  input  logic                    flush,
  output logic                    stg_trigger,
  output logic                    stg_push,
  output logic                    stg_pop,
  output logic                    stg_commit,
  output logic                    stg_reset,
  output logic [WIDTH-1:0]        stg_data,
  output logic [ADDR_WIDTH-1:0]   stg_addr,
  output logic [ADDR_WIDTH-1:0]   tos_addr,
  output logic [$clog2(DEPTH):0]  inflight,
  output logic                    busy,
  output logic [31:0]             stat_stalls
);

  localparam int IW = $clog2(DEPTH) + 1;
  localparam logic [IW-1:0] DEPTH_C = IW'(DEPTH);
  localparam logic [IW-1:0] I_ONE = IW'(1);
  localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    RESYNC = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [IW-1:0] infl_d;
  logic [ADDR_WIDTH-1:0] addr_c;
  logic run_st, rsy_st;

  // Slot address the action touches; also the new top on a trigger.
  always_comb begin
    addr_c = tos_addr;
    unique case (1'b1)
      (req_push && !req_pop): addr_c = tos_addr + A_ONE;
      (req_pop && !req_push): addr_c = tos_addr - A_ONE;
      default: ;
    endcase
  end

  // Outputs are forced low while reset is held.
  always_comb begin
    run_st      = (state_q == RUN);
    rsy_st      = (state_q == RESYNC);
    req_ready   = reset_n && run_st && !flush
                  && (inflight < DEPTH_C);
    cmt_ready   = reset_n && (inflight != '0) && !rsy_st;
    stg_trigger = req_valid && req_ready;
    stg_commit  = cmt_valid && cmt_ready;
    stg_push    = reset_n && req_push;
    stg_pop     = reset_n && req_pop;
    stg_data    = reset_n ? req_data : '0;
    stg_addr    = reset_n ? addr_c : '0;
    stg_reset   = reset_n && rsy_st;
    busy        = reset_n && !run_st;
  end

  always_comb begin
    infl_d = inflight;
    if (stg_trigger && !stg_commit)
      infl_d = inflight + I_ONE;
    else if (!stg_trigger && stg_commit)
      infl_d = inflight - I_ONE;
  end

  // DRAIN looks at next-cycle occupancy so a
  // commit that empties the count moves on now.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:    if (flush) state_d = DRAIN;
      DRAIN:  if (infl_d == '0) state_d = RESYNC;
      RESYNC: state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= RUN;
      tos_addr <= '0;
      inflight <= '0;
    end else begin
      state_q  <= state_d;
      inflight <= infl_d;
      if (rsy_st)
        tos_addr <= '0;
      else if (stg_trigger)
        tos_addr <= addr_c;
    end
  end

`ifdef RAS_CTRL_STATS_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stall_q <= '0;
    else if (req_valid && !req_ready
             && (stall_q != '1))
      stall_q <= stall_q + 32'd1;
  end

  assign stat_stalls = stall_q;
`else
  assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_ras_ctrl.sv
// tb_ras_ctrl: randomized + directed bench for ras_ctrl.
// Scoreboard of stage actions, checked by a monitor against a reference model.
module tb_ras_ctrl;

  localparam int DEPTH = 16;
  localparam int WIDTH = 32;
  localparam int AW    = 10;
  localparam int IW    = 5;
  localparam int AMOD  = 1 << AW;

`ifdef RAS_CTRL_STATS_EN
  localparam logic [63:0] EXP_ST4 = 64'd4;
`else
  localparam logic [63:0] EXP_ST4 = 64'd0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic req_valid = 1'b0;
  logic req_push = 1'b0;
  logic req_pop = 1'b0;
  logic [WIDTH-1:0] req_data = '0;
  logic req_ready;
  logic cmt_valid = 1'b0;
  logic cmt_ready;
  logic flush = 1'b0;
  logic stg_trigger, stg_push, stg_pop;
  logic stg_commit, stg_reset;
  logic [WIDTH-1:0] stg_data;
  logic [AW-1:0] stg_addr, tos_addr;
  logic [IW-1:0] inflight;
  logic busy;
  logic [31:0] stat_stalls;

  always #5 clk = ~clk;

  ras_ctrl #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_push(req_push),
    .req_pop(req_pop), .req_data(req_data),
    .req_ready(req_ready),
    .cmt_valid(cmt_valid), .cmt_ready(cmt_ready),
    .flush(flush),
    .stg_trigger(stg_trigger), .stg_push(stg_push),
    .stg_pop(stg_pop), .stg_commit(stg_commit),
    .stg_reset(stg_reset), .stg_data(stg_data),
    .stg_addr(stg_addr), .tos_addr(tos_addr),
    .inflight(inflight), .busy(busy),
    .stat_stalls(stat_stalls)
  );

  typedef struct {
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
    bit               pu;
    bit               po;
  } sb_t;

  sb_t sb[$];
  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 0;

  // Reference model: stack pointer as an integer,
  // outstanding count, and flush-recovery phase flags.
  int m_tos, m_infl, n_tos, n_infl;
  bit m_drain, m_rsy, n_drain, n_rsy;
  longint m_stalls, n_stalls;
  bit e_ready, e_trig, e_cmt_ready, e_commit;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h",
                  nm, act, exp);
  endtask

  task automatic model_reset();
    n_tos = 0; n_infl = 0;
    n_drain = 0; n_rsy = 0;
    n_stalls = 0;
  endtask

  task automatic cyc(input bit v, input bit pu,
                     input bit po,
                     input logic [31:0] d,
                     input bit cv, input bit fl);
    int dlt;
    int ea;
    sb_t e;
    @(negedge clk);
    m_tos = n_tos; m_infl = n_infl;
    m_drain = n_drain; m_rsy = n_rsy;
    m_stalls = n_stalls;
    req_valid = v; req_push = pu; req_pop = po;
    req_data = d; cmt_valid = cv; flush = fl;
    #1;
    e_ready = !m_drain && !m_rsy && !fl
              && (m_infl < DEPTH);
    e_trig = v && e_ready;
    dlt = (pu && !po) ? 1 : ((po && !pu) ? -1 : 0);
    ea = (m_tos + dlt + AMOD) % AMOD;
    e_cmt_ready = (m_infl > 0) && !m_rsy;
    e_commit = cv && e_cmt_ready;
    if (e_trig) begin
      e.addr = ea[AW-1:0];
      e.data = d; e.pu = pu; e.po = po;
      sb.push_back(e);
    end
    n_infl = m_infl + int'(e_trig) - int'(e_commit);
    n_tos = m_rsy ? 0 : (e_trig ? ea : m_tos);
    n_drain = m_drain;
    n_rsy = 0;
    if (m_rsy) n_drain = 0;
    else if (m_drain) begin
      if (n_infl == 0) begin
        n_drain = 0; n_rsy = 1;
      end
    end else if (fl) n_drain = 1;
    n_stalls = m_stalls;
`ifdef RAS_CTRL_STATS_EN
    if (v && !e_ready && n_stalls < 64'hFFFF_FFFF)
      n_stalls++;
`endif
    chk_en = 1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 32'h0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    chk_en = 0;
    reset_n = 1'b0;
    req_valid = 1; req_push = 1; req_pop = 0;
    req_data = 32'hDEAD_BEEF;
    cmt_valid = 1; flush = 0;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_cmt_ready", cmt_ready, 0);
    chk("rst_trigger", stg_trigger, 0);
    chk("rst_stg_push", stg_push, 0);
    chk("rst_stg_commit", stg_commit, 0);
    chk("rst_stg_reset", stg_reset, 0);
    chk("rst_stg_addr", stg_addr, 0);
    chk("rst_stg_data", stg_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tos", tos_addr, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_stalls", stat_stalls, 0);
    @(negedge clk);
    reset_n = 1'b1;
    req_valid = 0; req_push = 0;
    cmt_valid = 0; req_data = '0;
    model_reset();
  endtask

  // Monitor: pops the scoreboard on each stage trigger
  // and checks status outputs against the model.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      #2;
      if (chk_en) begin
        chk("req_ready", req_ready, e_ready);
        chk("stg_trigger", stg_trigger, e_trig);
        if (stg_trigger) begin
          chk("sb_nonempty", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("stg_addr", stg_addr, e.addr);
            chk("stg_data", stg_data, e.data);
            chk("stg_push", stg_push, e.pu);
            chk("stg_pop", stg_pop, e.po);
          end
        end
        chk("cmt_ready", cmt_ready, e_cmt_ready);
        chk("stg_commit", stg_commit, e_commit);
        chk("busy", busy, m_drain || m_rsy);
        chk("stg_reset", stg_reset, m_rsy);
        chk("tos_addr", tos_addr, m_tos);
        chk("inflight", inflight, m_infl);
        chk("stat_stalls", stat_stalls, m_stalls);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    do_reset();

    // three pushes
    cyc(1, 1, 0, 32'hA, 0, 0);
    chk("ex_push1_addr", stg_addr, 1);
    cyc(1, 1, 0, 32'hB, 0, 0);
    chk("ex_push2_addr", stg_addr, 2);
    cyc(1, 1, 0, 32'hC, 0, 0);
    chk("ex_push3_addr", stg_addr, 3);
    idle();
    chk("ex_push_tos", tos_addr, 3);
    chk("ex_push_infl", inflight, 3);
    repeat (3) cyc(0, 0, 0, 0, 1, 0);

    // pointer wrap below zero and back
    repeat (3) cyc(1, 0, 1, 0, 0, 0);
    idle();
    chk("ex_wrap_tos0", tos_addr, 0);
    cyc(1, 0, 1, 0, 0, 0);
    chk("ex_wrap_pop_addr", stg_addr, 10'h3FF);
    idle();
    chk("ex_wrap_tos", tos_addr, 10'h3FF);
    cyc(1, 1, 0, 32'h55, 0, 0);
    chk("ex_wrap_push_addr", stg_addr, 0);
    idle();
    chk("ex_wrap_tos_back", tos_addr, 0);

    // fill to DEPTH, then stall
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      cyc(1, 1, 0, 32'h100 + i, 0, 0);
    repeat (4) cyc(1, 1, 0, 32'h999, 0, 0);
    idle();
    chk("ex_stall_count", stat_stalls, EXP_ST4);
    chk("ex_full_infl", inflight, DEPTH);
    cyc(1, 1, 0, 32'h777, 1, 0);
    chk("ex_full_trig", stg_trigger, 0);
    chk("ex_full_commit", stg_commit, 1);
    idle();
    chk("ex_full_infl15", inflight, 15);
    chk("ex_full_busy", busy, 0);

    // replace top, then flush with two outstanding
    do_reset();
    for (int i = 0; i < 5; i++)
      cyc(1, 1, 0, 32'h200 + i, 0, 0);
    cyc(1, 1, 1, 32'h3AB, 0, 0);
    chk("ex_repl_addr", stg_addr, 5);
    idle();
    chk("ex_repl_tos", tos_addr, 5);
    chk("ex_repl_infl", inflight, 6);
    repeat (4) cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 1, 0, 32'h1, 0, 1);
    chk("ex_flush_trig", stg_trigger, 0);
    idle();
    chk("ex_drain_busy", busy, 1);
    chk("ex_drain_ready", req_ready, 0);
    cyc(0, 0, 0, 0, 1, 0);
    idle();
    chk("ex_drain_stay", stg_reset, 0);
    cyc(0, 0, 0, 0, 1, 0);
    idle();
    chk("ex_resync_pulse", stg_reset, 1);
    chk("ex_resync_busy", busy, 1);
    idle();
    chk("ex_resync_end", stg_reset, 0);
    chk("ex_resync_tos", tos_addr, 0);
    chk("ex_resync_run", busy, 0);

    // reset during drain
    cyc(1, 1, 0, 32'h10, 0, 0);
    cyc(1, 1, 0, 32'h11, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    idle();
    chk("ex_mid_busy", busy, 1);
    do_reset();
    idle();
    chk("ex_abort_busy", busy, 0);
    chk("ex_abort_ready", req_ready, 1);
    chk("ex_abort_nors", stg_reset, 0);
    idle();
    chk("ex_abort_nors2", stg_reset, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 10) < 7,
          $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1,
          $urandom,
          ($urandom % 10) < 4,
          ($urandom % 50) == 0);
    end
    idle();
    idle();
    #5;
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
